// File: rtl/calib_packet_mc.sv
// calib_packet_mc: multi-channel calibration packetiser for the TDC path.
// Filters per-shot samples by channel, serialises each record MSB-first
// into a ping-pong packet RAM and hands filled banks to the sender.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_calibrate_flag        session enable (level)
//   i_newsig_sync           sample strobe (1 cycle)
//   i_rise_data/i_fall_data TDC edges, DATA_W bits
//   i_code_angle            encoder angle
//   i_tdc_lasernum          laser index
//   i_chan_mask             per-channel accept mask
//   i_packet_dots           dots per packet (0 or >DOTS_MAX -> DOTS_MAX)
//   i_cali_pointnum         accepted samples per session
//   i_busy                  sender still reading the outgoing bank
//   o_calib_wren/wrdata/wraddr  packet RAM byte write port
//   o_calib_pingpang        bank select, toggles on every make
//   o_calib_points          dots in the released packet
//   o_calib_make            packet ready pulse
//   o_calib_cycle_done      session complete pulse
//   o_drop_cnt              saturating count of strobes seen while busy
//   o_active                FSM not idle
module calib_packet_mc #(
    parameter int DATA_W      = 16,
    parameter int CH_W        = 4,
    parameter int NCH         = 4,
    parameter int DOTS_MAX    = 100,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_calibrate_flag,
    input  logic              i_newsig_sync,
    input  logic [DATA_W-1:0] i_rise_data,
    input  logic [DATA_W-1:0] i_fall_data,
    input  logic [15:0]       i_code_angle,
    input  logic [CH_W-1:0]   i_tdc_lasernum,
    input  logic [NCH-1:0]    i_chan_mask,
    input  logic [15:0]       i_packet_dots,
    input  logic [15:0]       i_cali_pointnum,
    input  logic              i_busy,
    output logic              o_calib_wren,
    output logic [7:0]        o_calib_wrdata,
    output logic [ADDR_W-1:0] o_calib_wraddr,
    output logic              o_calib_pingpang,
    output logic [15:0]       o_calib_points,
    output logic              o_calib_make,
    output logic              o_calib_cycle_done,
    output logic [15:0]       o_drop_cnt,
    output logic              o_active
);

    localparam int REC_W     = 2 * DATA_W + 32;
    localparam int REC_BYTES = REC_W / 8;
    localparam int K_W       = $clog2(REC_BYTES + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_CLOSE,
        S_HOLD,
        S_MAKE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [15:0]       pkt_size;
    logic [15:0]       dot_cnt;
    logic [15:0]       sess_cnt;
    logic [REC_W-1:0]  rec_sr;
    logic [K_W-1:0]    byte_k;
    logic [ADDR_W-1:0] byte_addr;
    logic [TO_W-1:0]   idle_cnt;
    logic [1:0]        done_cnt;
    logic              done_flag;

    logic              lane_ok;
    logic              accept;
    logic              to_hit;
    logic              fire;
    logic              drop_evt;
    logic              sess_full;
    logic              last_byte;
    logic [15:0]       eff_size;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (i_calibrate_flag) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!i_calibrate_flag) state_d = S_IDLE;
                else if (accept)       state_d = S_WRITE;
                else if (to_hit)       state_d = S_MAKE;
            end
            S_WRITE: begin
                if (last_byte) state_d = S_CLOSE;
            end
            S_CLOSE: begin
                if (sess_full)                state_d = S_MAKE;
                else if (dot_cnt >= pkt_size) state_d = S_MAKE;
                else if (!i_calibrate_flag)   state_d = S_IDLE;
                else                          state_d = S_WAIT;
            end
            S_MAKE, S_HOLD: begin
                if (i_busy)         state_d = S_HOLD;
                else if (done_flag) state_d = S_DONE;
                else                state_d = S_WAIT;
            end
            S_DONE: begin
                if (done_cnt == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control decode for the datapath
    always_comb begin
        lane_ok = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(i_tdc_lasernum) == i && i_chan_mask[i]) lane_ok = 1'b1;
        end
        accept = (state == S_WAIT) && i_calibrate_flag
               && i_newsig_sync && lane_ok;
        to_hit = (state == S_WAIT) && (dot_cnt != 16'd0)
               && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
        fire = ((state == S_MAKE) || (state == S_HOLD)) && !i_busy;
        drop_evt = i_newsig_sync
                 && (state inside {S_WRITE, S_CLOSE, S_HOLD, S_MAKE, S_DONE});
        sess_full = (sess_cnt >= i_cali_pointnum);
        last_byte = (byte_k == K_W'(REC_BYTES - 1));
        if (i_packet_dots == 16'd0 || i_packet_dots > 16'(DOTS_MAX))
            eff_size = 16'(DOTS_MAX);
        else
            eff_size = i_packet_dots;
    end

    // Registered datapath and outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_calib_wren       <= 1'b0;
            o_calib_wrdata     <= 8'h00;
            o_calib_wraddr     <= '0;
            o_calib_pingpang   <= 1'b0;
            o_calib_points     <= 16'(DOTS_MAX);
            o_calib_make       <= 1'b0;
            o_calib_cycle_done <= 1'b0;
            o_drop_cnt         <= 16'd0;
            o_active           <= 1'b0;
            pkt_size           <= 16'(DOTS_MAX);
            dot_cnt            <= 16'd0;
            sess_cnt           <= 16'd0;
            rec_sr             <= '0;
            byte_k             <= '0;
            byte_addr          <= '0;
            idle_cnt           <= '0;
            done_cnt           <= 2'd0;
            done_flag          <= 1'b0;
        end else begin
            o_calib_wren       <= 1'b0;
            o_calib_make       <= 1'b0;
            o_calib_cycle_done <= 1'b0;
            o_active           <= (state_d != S_IDLE);
            if (drop_evt && o_drop_cnt != 16'hFFFF)
                o_drop_cnt <= o_drop_cnt + 16'd1;
            unique case (state)
                S_IDLE: begin
                    dot_cnt    <= 16'd0;
                    sess_cnt   <= 16'd0;
                    byte_addr  <= '0;
                    o_drop_cnt <= 16'd0;
                    idle_cnt   <= '0;
                    done_cnt   <= 2'd0;
                    done_flag  <= 1'b0;
                    pkt_size   <= eff_size;
                end
                S_WAIT: begin
                    if (accept) begin
                        rec_sr   <= {i_rise_data, i_fall_data,
                                     i_code_angle, 16'(i_tdc_lasernum)};
                        dot_cnt  <= dot_cnt + 16'd1;
                        sess_cnt <= sess_cnt + 16'd1;
                        idle_cnt <= '0;
                        byte_k   <= '0;
                    end else if (dot_cnt != 16'd0) begin
                        // Idle time only matters once a partial packet exists
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    o_calib_wren   <= 1'b1;
                    o_calib_wrdata <= rec_sr[REC_W-1 -: 8];
                    o_calib_wraddr <= byte_addr;
                    byte_addr      <= byte_addr + 1'b1;
                    rec_sr         <= {rec_sr[REC_W-9:0], 8'h00};
                    byte_k         <= byte_k + 1'b1;
                end
                S_CLOSE: begin
                    if (sess_full) done_flag <= 1'b1;
                end
                S_MAKE, S_HOLD: begin
                    if (!i_busy) begin
                        o_calib_points     <= dot_cnt;
                        o_calib_pingpang   <= ~o_calib_pingpang;
                        o_calib_make       <= 1'b1;
                        o_calib_cycle_done <= done_flag;
                        dot_cnt            <= 16'd0;
                        byte_addr          <= '0;
                        idle_cnt           <= '0;
                        done_cnt           <= 2'd0;
                    end
                end
                S_DONE: begin
                    done_cnt <= done_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/calib_packet_mc.md
# calib_packet_mc

Multi-channel, parametrised calibration packetiser for the TDC calibration path. It captures per-shot calibration samples (rise, fall, encoder angle, laser index) and filters them by channel mask. Accepted samples are serialised MSB-first, one byte per cycle, into a ping-pong packet RAM. Each filled bank is handed to the packet sender with a make pulse. Compared with the single-channel packer it adds:

- run-time packet size
- channel filtering
- a timeout flush of partial packets
- back-pressure from the sender
- drop accounting

## Interface
Parameters:
- DATA_W, 16, rise/fall width; multiple of 8
- CH_W, 4, laser index width; ≤16
- NCH, 4, channels honoured (index < NCH); ≤16
- DOTS_MAX, 100, max dots per packet; reset value of o_calib_points
- ADDR_W, 10, byte address width; DOTS_MAX·REC_BYTES ≤ 2^ADDR_W
- TIMEOUT_CYC, 4096, idle cycles before a partial packet is flushed
- Derived: REC_BYTES = (2·DATA_W+32)/8, which is 8 at the default DATA_W.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_calibrate_flag  in  1  session enable, level
- i_newsig_sync  in  1  sample strobe, 1 cycle
- i_rise_data / i_fall_data  in  DATA_W  TDC edges
- i_code_angle  in  16  encoder angle
- i_tdc_lasernum  in  CH_W  laser index
- i_chan_mask  in  NCH  1 = channel accepted
- i_packet_dots  in  16  dots per packet; 0 or >DOTS_MAX means DOTS_MAX
- i_cali_pointnum  in  16  accepted samples per session
- i_busy  in  1  sender still reading the bank about to be released
- o_calib_wren  out  1  RAM write enable
- o_calib_wrdata  out  8  RAM byte
- o_calib_wraddr  out  ADDR_W  byte address within bank
- o_calib_pingpang  out  1  bank select; toggles at each make
- o_calib_points  out  16  dots in released packet
- o_calib_make  out  1  packet ready pulse
- o_calib_cycle_done  out  1  session complete pulse
- o_drop_cnt  out  16  saturating count of rejected strobes
- o_active  out  1  state ≠ IDLE

## Operation
- States: IDLE, WAIT, WRITE, CLOSE, HOLD, MAKE, DONE.
- IDLE:
  - i_calibrate_flag=1 → WAIT.
  - Clear the dot count, session count, byte address and o_drop_cnt.
  - Latch the effective packet size P.
- WAIT: on i_newsig_sync, the sample is accepted only if i_tdc_lasernum < NCH and i_chan_mask[lasernum]=1.
  - Accepted: capture the record {rise, fall, angle, 16'(lasernum) zero-extended}, increment the dot and session counts, → WRITE.
  - Masked or out-of-range: ignore silently, with no drop count.
- WRITE: emit REC_BYTES bytes on consecutive cycles at address dot_index·REC_BYTES + k, k = 0…REC_BYTES−1. After the last byte → CLOSE.
- CLOSE, evaluated in priority order:
  1. Session count ≥ i_cali_pointnum → MAKE with the done flag set.
  2. Dot count ≥ P → MAKE.
  3. i_calibrate_flag=0 → IDLE; the partial packet is discarded with no make.
  4. Otherwise → WAIT.
- Timeout: in WAIT with dot count ≥ 1, a counter of cycles without an accepted sample reaching TIMEOUT_CYC → MAKE. The counter restarts on each accept.
- Flag loss in WAIT → IDLE with no make. Flag loss in WRITE: finish the record, then CLOSE applies the rules above.
- MAKE:
  - If i_busy=1, → HOLD and stay there until i_busy=0.
  - Otherwise, in one cycle: o_calib_points ← dot count, toggle o_calib_pingpang, pulse o_calib_make; if the done flag is set, also pulse o_calib_cycle_done.
  - Then clear the dot count and byte address, and go → DONE if done, else → WAIT.
- DONE: hold 4 cycles → IDLE.
- Drops: a strobe seen in WRITE, CLOSE, HOLD, MAKE or DONE increments o_drop_cnt, saturating at 16'hFFFF.

## Timing
- Reset values:
  - o_calib_wren, o_calib_wrdata, o_calib_wraddr, o_calib_pingpang, o_calib_make, o_calib_cycle_done, o_drop_cnt, o_active: all 0
  - o_calib_points: DOTS_MAX
- All outputs are registered.
- Sample accepted at cycle T: o_calib_wren is high T+2 … T+REC_BYTES+1, with byte k at T+2+k.
- The next sample is acceptable from T+REC_BYTES+2, which is T+10 at the default sizes; an earlier strobe is a drop.
- Make latency: o_calib_make asserts at T+REC_BYTES+3 after the accept that closes the packet, plus any HOLD cycles.
- The make pulse is exactly 1 cycle wide. Bank data is complete before make.
- Reset mid-operation returns everything to reset values immediately. No make is issued.

## Test plan
- Defaults, P=3, i_cali_pointnum=3, all channels unmasked, rise=16'hA1B2, fall=16'hC3D4, angle=16'h0123, lasernum=2, strobes 12 cycles apart → 24 bytes at addresses 0…23, bytes 0…7 = A1 B2 C3 D4 01 23 00 02; one make with points=3, pingpang=1, cycle_done pulse in the same cycle.
- i_chan_mask=4'b1011, strobes on lasernum 2 then 0 → only the lasernum-0 record is written at addresses 0…7; o_drop_cnt=0.
- Two strobes 5 cycles apart → second is dropped, o_drop_cnt=1, no bytes written for it.
- P=100, i_cali_pointnum=250 → makes with points 100, 100, 50; pingpang toggles 1, 0, 1; cycle_done only on the third.
- One sample, then silence for TIMEOUT_CYC cycles → make with points=1 and no cycle_done; the next accepted sample is written at address 0.
- Packet fills while i_busy=1 for 20 cycles → make is delayed 20 cycles; strobes during the hold increment o_drop_cnt.
